// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared Funct3 codes, FSM encoding and default timeout for the MEM-stage LSU
package lsu_pkg;

  localparam int DEFAULT_TIMEOUT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access width lives in Funct3[1:0] for every legal code
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/response bus between the LSU and memory
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// rtl/mem_stage_lsu_load_align.sv - extracts and extends the addressed byte/half of a loaded word
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      F3_W:    result = rdata;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: checks, issues and formats one data-memory access
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [31:0]     ALUResultM,
  input  logic [31:0]     WriteDataM,
  output logic [31:0]     ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  mem_stage_lsu_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   addr_q, wdata_q, wdata_d, load_data;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q;
  logic          we_q, req_c;
  logic          access, illegal, misaligned, start, fault, timeout;

  always_comb begin
    access  = MemReadM | MemWriteM;
    illegal = (MemReadM & MemWriteM) | (Funct3M == 3'b011) | (Funct3M[2:1] == 2'b11)
            | (MemWriteM & Funct3M[2]);
    case (Funct3M[1:0])
      SZ_W:    misaligned = |ALUResultM[1:0];
      SZ_H:    misaligned = ALUResultM[0];
      default: misaligned = 1'b0;
    endcase
    start   = access & ~illegal & ~misaligned;
    fault   = access & (illegal | misaligned);
    // Ready on the last allowed cycle still wins over the timeout
    timeout = (wait_cnt == CW'(TIMEOUT - 1)) & ~dmem.dmem_ready;
  end

  always_comb begin
    case (Funct3M[1:0])
      SZ_B: begin
        be_d    = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_REQ;
      S_REQ:   if (dmem.dmem_ready || timeout) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    StallM    = 1'b0;
    MisalignM = 1'b0;
    BusErrM   = 1'b0;
    req_c     = 1'b0;
    case (state)
      S_IDLE: begin
        StallM    = start;
        MisalignM = fault;
      end
      S_REQ: begin
        StallM  = 1'b1;
        req_c   = 1'b1;
        BusErrM = timeout;
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ReadDataM <= 32'h0000_0000;
      wait_cnt  <= '0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      be_q      <= 4'b0000;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q   <= ALUResultM;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            f3_q     <= Funct3M;
            we_q     <= MemWriteM;
            wait_cnt <= '0;
          end else if (fault) begin
            ReadDataM <= 32'h0000_0000;
          end
        end
        S_REQ: begin
          if (dmem.dmem_ready) begin
            if (!we_q) ReadDataM <= load_data;
          end else if (timeout) begin
            ReadDataM <= 32'h0000_0000;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req   = req_c;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

endmodule
